// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: head light codes used by the light drivers
// and the phase encoding of the intersection sequencer.
package tl_pkg;

    localparam logic [1:0] LT_IDLE   = 2'd0;
    localparam logic [1:0] LT_RED    = 2'd1;
    localparam logic [1:0] LT_GREEN  = 2'd2;
    localparam logic [1:0] LT_YELLOW = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_AR_NS = 4'd1,
        S_NS_G  = 4'd2,
        S_NS_Y  = 4'd3,
        S_AR_EW = 4'd4,
        S_WALK  = 4'd5,
        S_EW_G  = 4'd6,
        S_EW_Y  = 4'd7
    } state_t;

endpackage

// File: rtl/phase_timer.sv
// Dwell counter for one phase: cleared on phase change, optionally frozen once
// the phase duration has been reached so a holding phase never wraps.
module phase_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       hold_at_done,
    input  logic [3:0] limit,
    output logic       done
);

    logic [3:0] cnt;

    // 5-bit compare so a limit of 15 cannot overflow; a limit of 0 acts like 1
    always_comb begin
        done = ({1'b0, cnt} + 5'd1) >= {1'b0, limit};
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= 4'd0;
        end else if (!(hold_at_done && done)) begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/intersection_ctrl.sv
// Four-way intersection sequencer: NS main road, EW side road, all-red
// clearance and latched side-road car / pedestrian requests.
module intersection_ctrl
    import tl_pkg::*;
#(
    parameter logic [3:0] NS_GREEN_TIME = 4'd4,
    parameter logic [3:0] EW_GREEN_TIME = 4'd3,
    parameter logic [3:0] YELLOW_TIME   = 4'd1,
    parameter logic [3:0] ALLRED_TIME   = 4'd1,
    parameter logic [3:0] WALK_TIME     = 4'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       ew_car,
    input  logic       ped_btn,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       walk,
    output logic       ped_ack
);

    state_t     state;
    state_t     next_state;
    logic       ew_pend;
    logic       ped_pend;
    logic [3:0] limit;
    logic       done;
    logic       timer_clear;
    logic [1:0] next_ns;
    logic [1:0] next_ew;
    logic       next_walk;
    logic       next_ack;
    logic       enter_ew_g;
    logic       enter_walk;

    always_comb begin
        limit = 4'd1;
        case (state)
            S_AR_NS, S_AR_EW: limit = ALLRED_TIME;
            S_NS_G:           limit = NS_GREEN_TIME;
            S_NS_Y, S_EW_Y:   limit = YELLOW_TIME;
            S_WALK:           limit = WALK_TIME;
            S_EW_G:           limit = EW_GREEN_TIME;
            default:          limit = 4'd1;
        endcase
    end

    assign timer_clear = !enable || (next_state != state);

    phase_timer u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (timer_clear),
        .hold_at_done (state == S_NS_G),
        .limit        (limit),
        .done         (done)
    );

    // NS green only yields to a latched request; WALK returns to NS without
    // extra clearance because both heads are already red
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  next_state = S_AR_NS;
            S_AR_NS: if (done) next_state = S_NS_G;
            S_NS_G:  if (done && (ew_pend || ped_pend)) next_state = S_NS_Y;
            S_NS_Y:  if (done) next_state = S_AR_EW;
            S_AR_EW: if (done) next_state = ped_pend ? S_WALK : S_EW_G;
            S_WALK:  if (done) next_state = ew_pend ? S_EW_G : S_NS_G;
            S_EW_G:  if (done) next_state = S_EW_Y;
            S_EW_Y:  if (done) next_state = S_AR_NS;
            default: next_state = S_IDLE;
        endcase
    end

    assign enter_ew_g = (next_state == S_EW_G) && (state != S_EW_G);
    assign enter_walk = (next_state == S_WALK) && (state != S_WALK);

    always_comb begin
        next_ns   = LT_RED;
        next_ew   = LT_RED;
        next_walk = 1'b0;
        next_ack  = enter_walk;
        case (next_state)
            S_IDLE: begin
                next_ns = LT_IDLE;
                next_ew = LT_IDLE;
            end
            S_NS_G:  next_ns = LT_GREEN;
            S_NS_Y:  next_ns = LT_YELLOW;
            S_EW_G:  next_ew = LT_GREEN;
            S_EW_Y:  next_ew = LT_YELLOW;
            S_WALK:  next_walk = 1'b1;
            default: begin
                next_ns = LT_RED;
                next_ew = LT_RED;
            end
        endcase
    end

    // Dropping enable behaves exactly like reset, including the request latches
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            state    <= S_IDLE;
            ew_pend  <= 1'b0;
            ped_pend <= 1'b0;
            ns_light <= LT_IDLE;
            ew_light <= LT_IDLE;
            walk     <= 1'b0;
            ped_ack  <= 1'b0;
        end else begin
            state    <= next_state;
            ew_pend  <= enter_ew_g ? 1'b0 : (ew_pend || ew_car);
            ped_pend <= enter_walk ? 1'b0 : (ped_pend || ped_btn);
            ns_light <= next_ns;
            ew_light <= next_ew;
            walk     <= next_walk;
            ped_ack  <= next_ack;
        end
    end

endmodule

// File: doc/intersection_ctrl.md
Name: intersection_ctrl

Overview:
- Four-way intersection sequencer built on the team's traffic-light state encoding.
- Drives two signal heads: north-south (NS, main road) and east-west (EW, side road).
- Inserts all-red clearance between the two directions and serves latched side-road car and pedestrian requests.
- Sits above the per-head light drivers and is the single source of light state for the crossing.

Parameters:
- NS_GREEN_TIME, 4'd4, minimum NS green duration in cycles.
- EW_GREEN_TIME, 4'd3, fixed EW green duration in cycles.
- YELLOW_TIME, 4'd1, yellow duration in cycles, both directions.
- ALLRED_TIME, 4'd1, all-red clearance duration in cycles.
- WALK_TIME, 4'd2, pedestrian walk phase duration in cycles.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous and active-low.
- enable  input  1  run enable; low forces IDLE.
- ew_car  input  1  EW vehicle sensor, level, sampled every cycle.
- ped_btn  input  1  pedestrian button, level, sampled every cycle.
- ns_light  output  2  NS head state: IDLE=0, RED=1, GREEN=2, YELLOW=3.
- ew_light  output  2  EW head state, same encoding.
- walk  output  1  pedestrian walk lamp.
- ped_ack  output  1  one-cycle pulse, first cycle of WALK.

Behaviour:
- Clocking and reset: single clk domain; rst_n is synchronous, active-low.
- All outputs are registered and decoded from the current state.
- Reset values: ns_light=0, ew_light=0, walk=0, ped_ack=0, state=S_IDLE, cnt=0, ew_pend=0, ped_pend=0.
- enable low at a clock edge has the same effect as reset, including clearing both pend latches. This applies mid-phase, even mid-yellow.
- Dwell counter: 4-bit cnt, cleared on every state change and incremented otherwise.
- Phase done when {1'b0,cnt}+1 >= {1'b0,T}, using 5-bit compare. A state therefore lasts exactly T cycles. T=0 behaves as T=1.
- In S_NS_G, cnt saturates at NS_GREEN_TIME-1 while holding.

States (ns/ew light, walk):
- S_IDLE (0/0, 0): goes to S_AR_NS on the first edge with enable=1.
- S_AR_NS (RED/RED, 0): ALLRED_TIME cycles, then S_NS_G.
- S_NS_G (GREEN/RED, 0): after the minimum time, exits to S_NS_Y only if ew_pend or ped_pend is set. Otherwise holds indefinitely.
- S_NS_Y (YELLOW/RED, 0): YELLOW_TIME cycles, then S_AR_EW.
- S_AR_EW (RED/RED, 0): ALLRED_TIME cycles, then S_WALK if ped_pend, else S_EW_G.
- S_WALK (RED/RED, 1): WALK_TIME cycles, then S_EW_G if ew_pend, else S_NS_G (no extra clearance needed).
- S_EW_G (RED/GREEN, 0): EW_GREEN_TIME cycles, then S_EW_Y.
- S_EW_Y (RED/YELLOW, 0): YELLOW_TIME cycles, then S_AR_NS.

Request latches:
- ew_pend: set by ew_car=1; cleared on the edge entering S_EW_G.
- ped_pend: set by ped_btn=1; cleared on the edge entering S_WALK.
- Clear wins over a simultaneous set.
- A request arriving after its phase is entered is held and served next cycle round.
- ped_ack is 1 exactly on the first S_WALK cycle.
- Invariant: ns_light and ew_light are never both GREEN or YELLOW. walk=1 only while both heads are RED.

Decomposition:
- Shared package tl_pkg:
  - light codes LT_IDLE/LT_RED/LT_GREEN/LT_YELLOW (2-bit), reused by the existing light driver;
  - the 4-bit state enum for this block.
- One sub-module, phase_timer: cnt register with clear, saturation and 5-bit done compare. The FSM, latches and output decode stay in intersection_ctrl.

Test Plan:
- Reset/enable:
  - Stimulus: rst_n=0 for 2 cycles, then rst_n=1, enable=1, no requests.
  - Required: outputs 0/0 while in reset; RED/RED for 1 cycle; then GREEN/RED held 20+ cycles.
- EW car:
  - Stimulus: ew_car pulsed 1 cycle during NS green, after 4+ green cycles.
  - Required: NS_Y 1, AR 1, EW_G 3, EW_Y 1, AR 1, then NS_G. ew_pend=0 after EW_G entry.
- Minimum green:
  - Stimulus: ew_car held at the first NS_G cycle.
  - Required: NS_G lasts exactly 4 cycles before YELLOW.
- Pedestrian with car:
  - Stimulus: ped_btn and ew_car pulsed together.
  - Required: NS_Y, AR_EW, then WALK for 2 cycles with walk=1; ped_ack on the first WALK cycle only; then EW_G.
- Pedestrian only:
  - Stimulus: ped_btn pulsed, no car.
  - Required: WALK, then directly GREEN/RED. A second press during WALK is served next round.
- Abort mid-phase:
  - Stimulus: enable=0 mid S_NS_Y with ped_pend set.
  - Required: next cycle all outputs 0. On re-enable, sequence restarts at S_AR_NS with no WALK.
